// File: rtl/afifo_rd_drain.sv
// Purpose: read-domain drain for the dual-clock AFIFO; pops words into a 2-entry skid buffer and emits a framed valid/ready stream.
// Latency: 2 cycles from rd_en to m_valid (pop at edge N, buffered at N+1); output is registered from the buffer head.
// Backpressure: pops are withheld whenever buffered plus in-flight words reach 2, so a stalled sink never loses data.
module afifo_rd_drain #(
   parameter int DATA_WIDTH = 32,
   parameter int PKT_LEN    = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_rd,
   input  logic                  rst_rd,
   input  logic                  enable,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   input  logic                  fifo_empty,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  pop_cnt
);

   localparam int            BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [1:0]            buf_cnt;     // words held: m_data is the head, buf_tail the second slot
   logic                  inflight;    // a pop was accepted last edge; its word lands this edge
   logic [DATA_WIDTH-1:0] buf_tail;
   logic [BW-1:0]         beat_cnt;    // packet position of the head word
   logic [2:0]            occ;
   logic                  pop_acc;
   logic                  xfer;

   // Occupancy counts the in-flight word so the buffer can never be overrun.
   always_comb begin
      occ        = {1'b0, buf_cnt} + {2'b00, inflight};
      fifo_rd_en = !rst_rd && enable && ((state != ST_IDLE) || enable) && (occ < 3'd2);
      pop_acc    = fifo_rd_en && !fifo_empty;
      m_valid    = (buf_cnt != 2'd0);
      xfer       = m_valid && m_ready;
      m_last     = m_valid && (beat_cnt == LAST_BEAT);
      busy       = (buf_cnt != 2'd0) || inflight;
   end

   // Next-state: DRAIN lets in-flight and buffered words leave before going idle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (enable) state_nxt = ST_RUN;
         ST_RUN:   if (!enable) state_nxt = (occ != 3'd0) ? ST_DRAIN : ST_IDLE;
         ST_DRAIN: begin
            if (enable)            state_nxt = ST_RUN;
            else if (occ == 3'd0)  state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_rd) begin
      if (rst_rd) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Skid buffer: capture the registered FIFO word, shift head on transfer, keep strict order.
   always_ff @(posedge clk_rd) begin
      if (rst_rd) begin
         buf_cnt  <= 2'd0;
         inflight <= 1'b0;
         m_data   <= '0;
         buf_tail <= '0;
      end else begin
         inflight <= pop_acc;
         case (buf_cnt)
            2'd0: begin
               if (inflight) begin
                  m_data  <= fifo_rdata;
                  buf_cnt <= 2'd1;
               end
            end
            2'd1: begin
               if (inflight && xfer) begin
                  m_data <= fifo_rdata;
               end else if (inflight) begin
                  buf_tail <= fifo_rdata;
                  buf_cnt  <= 2'd2;
               end else if (xfer) begin
                  buf_cnt <= 2'd0;
               end
            end
            default: begin
               if (xfer) begin
                  m_data <= buf_tail;
                  if (inflight) buf_tail <= fifo_rdata;
                  else          buf_cnt  <= 2'd1;
               end
            end
         endcase
      end
   end

   // Beat position survives enable toggles; only reset clears it.
   always_ff @(posedge clk_rd) begin
      if (rst_rd)
         beat_cnt <= '0;
      else if (xfer)
         beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
   end

   // Free-running count of accepted pops, wraps naturally.
   always_ff @(posedge clk_rd) begin
      if (rst_rd)       pop_cnt <= '0;
      else if (pop_acc) pop_cnt <= pop_cnt + 1'b1;
   end

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Purpose: directed bench for afifo_rd_drain with a simple AFIFO read-port model per instance.
// Latency: model returns rdata one edge after an accepted pop, like the real AFIFO.
// Backpressure: sink ready is driven directly by the directed steps.
module tb_afifo_rd_drain;

   logic        clk_rd = 1'b0;
   logic        rst_rd;
   always #5 clk_rd = ~clk_rd;

   // Instance 1: default parameters
   logic        enable, m_ready, mask_empty;
   logic        fifo_rd_en, fifo_empty, m_valid, m_last, busy;
   logic [31:0] fifo_rdata = '0;
   logic [31:0] m_data;
   logic [15:0] pop_cnt;
   logic [31:0] mem [0:31];
   int          wr_idx = 0;
   int          rd_idx = 0;

   // Instance 2: single-beat packets, 4-bit pop counter
   logic        en2, rdy2;
   logic        rd_en2, empty2, vld2, last2, busy2;
   logic [31:0] rdata2 = '0;
   logic [31:0] dat2;
   logic [3:0]  pop_cnt2;
   logic [31:0] mem2 [0:31];
   int          wr2 = 0;
   int          rd2 = 0;

   afifo_rd_drain dut (
      .clk_rd(clk_rd), .rst_rd(rst_rd), .enable(enable),
      .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .pop_cnt(pop_cnt));

   afifo_rd_drain #(.DATA_WIDTH(32), .PKT_LEN(1), .CNT_WIDTH(4)) dut2 (
      .clk_rd(clk_rd), .rst_rd(rst_rd), .enable(en2),
      .fifo_rd_en(rd_en2), .fifo_rdata(rdata2), .fifo_empty(empty2),
      .m_valid(vld2), .m_ready(rdy2), .m_data(dat2), .m_last(last2),
      .busy(busy2), .pop_cnt(pop_cnt2));

   assign fifo_empty = (rd_idx == wr_idx) || mask_empty;
   assign empty2     = (rd2 == wr2);

   // AFIFO read-port models: registered data one edge after an accepted pop
   always @(posedge clk_rd) begin
      if (fifo_rd_en && !fifo_empty) begin
         fifo_rdata <= mem[rd_idx];
         rd_idx     <= rd_idx + 1;
      end
      if (rd_en2 && !empty2) begin
         rdata2 <= mem2[rd2];
         rd2    <= rd2 + 1;
      end
   end

   // Stream monitors: inputs only change just after posedge, so negedge sees the coming transfer
   logic [31:0] rx_dat  [0:63];
   logic        rx_lst  [0:63];
   int          rx_cnt = 0;
   logic [31:0] rx2_dat [0:63];
   logic        rx2_lst [0:63];
   int          rx2_cnt = 0;
   always @(negedge clk_rd) begin
      if (m_valid && m_ready) begin
         rx_dat[rx_cnt] <= m_data;
         rx_lst[rx_cnt] <= m_last;
         rx_cnt         <= rx_cnt + 1;
      end
      if (vld2 && rdy2) begin
         rx2_dat[rx2_cnt] <= dat2;
         rx2_lst[rx2_cnt] <= last2;
         rx2_cnt          <= rx2_cnt + 1;
      end
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_rd);
      #1;
   endtask

   task automatic wait_rx(input int target, input bit second, input int budget);
      int n = 0;
      while (((second ? rx2_cnt : rx_cnt) < target) && n < budget) begin
         tick();
         n++;
      end
      chk("rx_timeout", {31'd0, ((second ? rx2_cnt : rx_cnt) >= target)}, 32'd1);
   endtask

   initial begin
      rst_rd = 1'b1; enable = 1'b1; m_ready = 1'b0; mask_empty = 1'b0;
      en2 = 1'b0; rdy2 = 1'b0;

      // Reset state, with enable high to prove rd_en is gated by reset
      tick();
      chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      chk("rst_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_last",  {31'd0, m_last}, 32'd0);
      chk("rst_data",  m_data, 32'd0);
      chk("rst_popcnt", {16'd0, pop_cnt}, 32'd0);
      enable = 1'b0;
      tick();
      rst_rd = 1'b0;

      // Basic flow: four words, sink always ready
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
      wr_idx = 4; m_ready = 1'b1; enable = 1'b1;
      tick();
      chk("basic_valid_n1", {31'd0, m_valid}, 32'd0);
      chk("basic_pop1", {16'd0, pop_cnt}, 32'd1);
      chk("basic_busy_inflight", {31'd0, busy}, 32'd1);
      tick();
      chk("basic_valid_n2", {31'd0, m_valid}, 32'd1);
      chk("basic_first", m_data, 32'h11);
      wait_rx(4, 1'b0, 20);
      for (int i = 0; i < 4; i++) begin
         chk("basic_data", rx_dat[i], 32'h11 * (i + 1));
         chk("basic_last", {31'd0, rx_lst[i]}, (i == 3) ? 32'd1 : 32'd0);
      end
      chk("basic_popcnt", {16'd0, pop_cnt}, 32'd4);

      // Back-pressure: eight words, sink stalled for ten cycles
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) mem[4 + i] = 32'hA0 + i;
      wr_idx = 12;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 3 || c == 10) begin
            chk("bp_popcnt", {16'd0, pop_cnt}, 32'd6);
            chk("bp_rd_en", {31'd0, fifo_rd_en}, 32'd0);
            chk("bp_hold", m_data, 32'hA0);
         end
      end
      chk("bp_valid", {31'd0, m_valid}, 32'd1);
      m_ready = 1'b1;
      wait_rx(12, 1'b0, 40);
      for (int i = 0; i < 8; i++) begin
         chk("bp_data", rx_dat[4 + i], 32'hA0 + i);
         chk("bp_last", {31'd0, rx_lst[4 + i]}, (i % 4 == 3) ? 32'd1 : 32'd0);
      end
      chk("bp_popcnt_end", {16'd0, pop_cnt}, 32'd12);

      // Empty flag toggling every cycle while rd_en stays high
      mask_empty = 1'b1;
      for (int i = 0; i < 4; i++) mem[12 + i] = 32'hC0 + i;
      wr_idx = 16;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0) begin
            chk("tog_popcnt0", {16'd0, pop_cnt}, 32'd12);
            chk("tog_no_valid0", {31'd0, m_valid}, 32'd0);
         end
         if (i == 1) begin
            chk("tog_popcnt1", {16'd0, pop_cnt}, 32'd13);
            chk("tog_no_valid1", {31'd0, m_valid}, 32'd0);
         end
         mask_empty = ~mask_empty;
      end
      mask_empty = 1'b0;
      chk("tog_popcnt", {16'd0, pop_cnt}, 32'd16);
      wait_rx(16, 1'b0, 20);
      for (int i = 0; i < 4; i++) chk("tog_data", rx_dat[12 + i], 32'hC0 + i);
      chk("tog_last", {31'd0, rx_lst[15]}, 32'd1);

      // Disable on the same edge a pop is accepted
      mem[16] = 32'hD0; mem[17] = 32'hD1; wr_idx = 18;
      tick();
      chk("dis_popcnt", {16'd0, pop_cnt}, 32'd17);
      chk("dis_busy_inflight", {31'd0, busy}, 32'd1);
      enable = 1'b0;
      #1;
      chk("dis_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      tick();
      chk("dis_state_drain", {30'd0, dut.state}, 32'd2);
      chk("dis_valid", {31'd0, m_valid}, 32'd1);
      chk("dis_data", m_data, 32'hD0);
      tick();
      chk("dis_busy_fall", {31'd0, busy}, 32'd0);
      chk("dis_state_drain2", {30'd0, dut.state}, 32'd2);
      tick();
      chk("dis_state_idle", {30'd0, dut.state}, 32'd0);
      tick(); tick();
      chk("dis_no_pop", {16'd0, pop_cnt}, 32'd17);
      chk("dis_rx_cnt", rx_cnt, 32'd17);
      chk("dis_rx_data", rx_dat[16], 32'hD0);

      // Sync reset with two words buffered
      m_ready = 1'b0; enable = 1'b1;
      mem[18] = 32'hE0; wr_idx = 19;
      tick(); tick(); tick();
      chk("sr_full_valid", {31'd0, m_valid}, 32'd1);
      chk("sr_full_head", m_data, 32'hD1);
      chk("sr_full_popcnt", {16'd0, pop_cnt}, 32'd19);
      rst_rd = 1'b1;
      for (int i = 0; i < 4; i++) mem[19 + i] = 32'hF0 + i;
      wr_idx = 23;
      #1;
      chk("sr_rd_en_comb", {31'd0, fifo_rd_en}, 32'd0);
      tick();
      chk("sr_valid", {31'd0, m_valid}, 32'd0);
      chk("sr_busy", {31'd0, busy}, 32'd0);
      chk("sr_popcnt", {16'd0, pop_cnt}, 32'd0);
      chk("sr_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      rst_rd = 1'b0; m_ready = 1'b1;
      wait_rx(21, 1'b0, 30);
      for (int i = 0; i < 4; i++) chk("sr_data", rx_dat[17 + i], 32'hF0 + i);
      chk("sr_last0", {31'd0, rx_lst[17]}, 32'd0);
      chk("sr_last3", {31'd0, rx_lst[20]}, 32'd1);
      chk("sr_popcnt_end", {16'd0, pop_cnt}, 32'd4);
      enable = 1'b0;

      // Single-beat packets and 4-bit pop counter wrap
      chk("wrap_last_idle", {31'd0, last2}, 32'd0);
      for (int i = 0; i < 17; i++) mem2[i] = 32'h100 + i;
      wr2 = 17; en2 = 1'b1; rdy2 = 1'b1;
      wait_rx(17, 1'b1, 120);
      for (int i = 0; i < 17; i++) begin
         chk("wrap_data", rx2_dat[i], 32'h100 + i);
         chk("wrap_last", {31'd0, rx2_lst[i]}, 32'd1);
      end
      chk("wrap_popcnt", {28'd0, pop_cnt2}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
